// File: rtl/syn_audio_pkg.sv
// Shared audio-path types and constants: bps_t, WM8731 codec register
// addresses, acortex WM8731 driver local-bus map, and sequencer state type.
// Latency: n/a (declarations only). Backpressure: n/a.
package syn_audio_pkg;

    typedef enum logic {
        BPS_16 = 1'b0,
        BPS_32 = 1'b1
    } bps_t;

    // WM8731 control register addresses (7-bit I2C register field)
    localparam logic [6:0] WM8731_R0_ADDR    = 7'h00;
    localparam logic [6:0] WM8731_R1_ADDR    = 7'h01;
    localparam logic [6:0] WM8731_R2_ADDR    = 7'h02;
    localparam logic [6:0] WM8731_R3_ADDR    = 7'h03;
    localparam logic [6:0] WM8731_R4_ADDR    = 7'h04;
    localparam logic [6:0] WM8731_R5_ADDR    = 7'h05;
    localparam logic [6:0] WM8731_R6_ADDR    = 7'h06;
    localparam logic [6:0] WM8731_R7_ADDR    = 7'h07;
    localparam logic [6:0] WM8731_R8_ADDR    = 7'h08;
    localparam logic [6:0] WM8731_R9_ADDR    = 7'h09;
    localparam logic [6:0] WM8731_RESET_ADDR = 7'h0F;

    // acortex WM8731 driver registers on the local bus
    localparam logic [7:0] ACORTEX_WMDRVR_CTRL   = 8'h00;
    localparam logic [7:0] ACORTEX_WMDRVR_STATUS = 8'h01;
    localparam logic [7:0] ACORTEX_WMDRVR_FS_DIV = 8'h02;

    // Codec table index width shared by the sequencer and the ROM
    localparam int ROM_IDX_W = 4;

    typedef enum logic [3:0] {
        IDLE_S,
        STOP_S,
        POLL_S,
        I2C_S,
        GAP_S,
        FSDIV_S,
        CTRL_S,
        DONE_S,
        ERR_S
    } seq_state_t;

    // Codec I2C payload: register address in [15:9], 9-bit value in [8:0]
    function automatic logic [15:0] wm8731_word(input logic [6:0] addr,
                                                input logic [8:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/syn_wm8731_cfg_rom.sv
// Codec register table: maps table index and sample width to the 16-bit I2C word.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//  idx  in  table entry (0 = soft reset, 1..9 = R1..R9; R9 activates the codec last)
//  bps  in  sample width, selects R7 input word length
//  word out {reg_addr[6:0], reg_data[8:0]}; zero for indices past the table
module syn_wm8731_cfg_rom
    import syn_audio_pkg::*;
(
    input  logic [ROM_IDX_W-1:0] idx,
    input  bps_t                 bps,
    output logic [15:0]          word
);

    logic [8:0] r7_data;

    always_comb begin
        // R7: I2S format (0x002), IWL=32 bit adds 0x00C
        r7_data = (bps == BPS_32) ? 9'h00E : 9'h002;
        word    = '0;
        case (idx)
            4'd0:    word = wm8731_word(WM8731_RESET_ADDR, 9'h000);
            4'd1:    word = wm8731_word(WM8731_R1_ADDR,    9'h017);
            4'd2:    word = wm8731_word(WM8731_R2_ADDR,    9'h079);
            4'd3:    word = wm8731_word(WM8731_R3_ADDR,    9'h079);
            4'd4:    word = wm8731_word(WM8731_R4_ADDR,    9'h012);
            4'd5:    word = wm8731_word(WM8731_R5_ADDR,    9'h000);
            4'd6:    word = wm8731_word(WM8731_R6_ADDR,    9'h000);
            4'd7:    word = wm8731_word(WM8731_R7_ADDR,    r7_data);
            4'd8:    word = wm8731_word(WM8731_R8_ADDR,    9'h000);
            4'd9:    word = wm8731_word(WM8731_R9_ADDR,    9'h001);
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/syn_wm8731_init_seq.sv
// WM8731 power-up/re-config sequencer: stop driver, poll idle, write codec table over I2C, program FS_DIV/CTRL.
// Latency: one registered step per bus response; every output is a flop.
// Backpressure: waits on lb_*_valid and i2c_done/i2c_nack indefinitely; init_start ignored while busy.
//  clk_ir/rst_sync_l             clock, synchronous active-low reset
//  init_start, cfg_*             start pulse and configuration (captured on accepted start)
//  init_busy/init_done/init_err  status (done/err sticky until next start)
//  i2c_req/i2c_wdata, i2c_done/i2c_nack   I2C master handshake
//  lb_wr_en/lb_rd_en/lb_addr/lb_wr_data, lb_wr_valid/lb_rd_valid/lb_rd_data  driver local bus
module syn_wm8731_init_seq
    import syn_audio_pkg::*;
#(
    parameter int P_LB_DATA_W = 16,
    parameter int P_LB_ADDR_W = 8,
    parameter int P_NUM_REGS  = 10,
    parameter int P_RETRY_MAX = 3,
    parameter int P_FS_DIV_W  = 11
)(
    input  logic                   clk_ir,
    input  logic                   rst_sync_l,
    input  logic                   init_start,
    input  logic                   cfg_dac_en,
    input  logic                   cfg_adc_en,
    input  bps_t                   cfg_bps,
    input  logic [P_FS_DIV_W-1:0]  cfg_fs_div,
    output logic                   init_busy,
    output logic                   init_done,
    output logic                   init_err,
    output logic                   i2c_req,
    output logic [15:0]            i2c_wdata,
    input  logic                   i2c_done,
    input  logic                   i2c_nack,
    output logic                   lb_wr_en,
    output logic                   lb_rd_en,
    output logic [P_LB_ADDR_W-1:0] lb_addr,
    output logic [P_LB_DATA_W-1:0] lb_wr_data,
    input  logic                   lb_wr_valid,
    input  logic                   lb_rd_valid,
    input  logic [P_LB_DATA_W-1:0] lb_rd_data
);

    localparam int RETRY_W = (P_RETRY_MAX > 1) ? $clog2(P_RETRY_MAX) : 1;
    localparam logic [ROM_IDX_W-1:0] LAST_IDX   = ROM_IDX_W'(P_NUM_REGS - 1);
    localparam logic [RETRY_W-1:0]   RETRY_LAST = RETRY_W'(P_RETRY_MAX - 1);

    localparam logic [P_LB_ADDR_W-1:0] ADDR_CTRL   = P_LB_ADDR_W'(ACORTEX_WMDRVR_CTRL);
    localparam logic [P_LB_ADDR_W-1:0] ADDR_STATUS = P_LB_ADDR_W'(ACORTEX_WMDRVR_STATUS);
    localparam logic [P_LB_ADDR_W-1:0] ADDR_FS_DIV = P_LB_ADDR_W'(ACORTEX_WMDRVR_FS_DIV);

    seq_state_t               state;
    logic [ROM_IDX_W-1:0]     idx;
    logic [RETRY_W-1:0]       retry;
    logic                     dac_q;
    logic                     adc_q;
    bps_t                     bps_q;
    logic [P_FS_DIV_W-1:0]    fs_div_q;
    logic [15:0]              rom_word;
    logic [P_LB_DATA_W-1:0]   fs_div_word;
    logic [P_LB_DATA_W-1:0]   ctrl_word;

    // Only the driver-idle flag in STATUS[0] matters here
    logic unused_status_bits;
    assign unused_status_bits = ^lb_rd_data[P_LB_DATA_W-1:1];

    assign fs_div_word = {{(P_LB_DATA_W-P_FS_DIV_W){1'b0}}, fs_div_q};
    assign ctrl_word   = {{(P_LB_DATA_W-3){1'b0}}, (bps_q == BPS_32), adc_q, dac_q};

    syn_wm8731_cfg_rom u_rom (
        .idx  (idx),
        .bps  (bps_q),
        .word (rom_word)
    );

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            state      <= IDLE_S;
            idx        <= '0;
            retry      <= '0;
            dac_q      <= 1'b0;
            adc_q      <= 1'b0;
            bps_q      <= BPS_16;
            fs_div_q   <= '0;
            init_busy  <= 1'b0;
            init_done  <= 1'b0;
            init_err   <= 1'b0;
            i2c_req    <= 1'b0;
            i2c_wdata  <= '0;
            lb_wr_en   <= 1'b0;
            lb_rd_en   <= 1'b0;
            lb_addr    <= '0;
            lb_wr_data <= '0;
        end else begin
            // Bus strobes are single-cycle; each state raises them only on the
            // cycle it issues a new request.
            lb_wr_en <= 1'b0;
            lb_rd_en <= 1'b0;

            unique case (state)
                IDLE_S, DONE_S, ERR_S: begin
                    if (init_start) begin
                        dac_q      <= cfg_dac_en;
                        adc_q      <= cfg_adc_en;
                        bps_q      <= cfg_bps;
                        fs_div_q   <= cfg_fs_div;
                        idx        <= '0;
                        retry      <= '0;
                        init_busy  <= 1'b1;
                        init_done  <= 1'b0;
                        init_err   <= 1'b0;
                        lb_wr_en   <= 1'b1;
                        lb_addr    <= ADDR_CTRL;
                        lb_wr_data <= '0;
                        state      <= STOP_S;
                    end
                end

                STOP_S: begin
                    if (lb_wr_valid) begin
                        lb_rd_en <= 1'b1;
                        lb_addr  <= ADDR_STATUS;
                        state    <= POLL_S;
                    end
                end

                POLL_S: begin
                    if (lb_rd_valid) begin
                        if (lb_rd_data[0]) begin
                            i2c_req   <= 1'b1;
                            i2c_wdata <= rom_word;
                            state     <= I2C_S;
                        end else begin
                            lb_rd_en <= 1'b1;
                        end
                    end
                end

                I2C_S: begin
                    // nack is checked first so a simultaneous done is treated as a failure
                    if (i2c_nack) begin
                        i2c_req <= 1'b0;
                        if (retry == RETRY_LAST) begin
                            init_err  <= 1'b1;
                            init_busy <= 1'b0;
                            state     <= ERR_S;
                        end else begin
                            retry <= retry + 1'b1;
                            state <= GAP_S;
                        end
                    end else if (i2c_done) begin
                        i2c_req <= 1'b0;
                        retry   <= '0;
                        if (idx == LAST_IDX) begin
                            lb_wr_en   <= 1'b1;
                            lb_addr    <= ADDR_FS_DIV;
                            lb_wr_data <= fs_div_word;
                            state      <= FSDIV_S;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= GAP_S;
                        end
                    end
                end

                // One cycle with req low between attempts/entries so the master
                // sees a fresh request; rom_word already reflects the new idx.
                GAP_S: begin
                    i2c_req   <= 1'b1;
                    i2c_wdata <= rom_word;
                    state     <= I2C_S;
                end

                FSDIV_S: begin
                    if (lb_wr_valid) begin
                        lb_wr_en   <= 1'b1;
                        lb_addr    <= ADDR_CTRL;
                        lb_wr_data <= ctrl_word;
                        state      <= CTRL_S;
                    end
                end

                CTRL_S: begin
                    if (lb_wr_valid) begin
                        init_done <= 1'b1;
                        init_busy <= 1'b0;
                        state     <= DONE_S;
                    end
                end

                default: state <= IDLE_S;
            endcase
        end
    end

endmodule
